fu_issue: RTL and testbench

- Issue stage that feeds the execute functional unit (ALU + shifter).
- Accepts RV32I instruction words with PC and register operands over a valid/ready handshake.
- Decodes them into operand A/B, funct_select, unit_sel and rd, and holds decoded operations in a 2-entry FIFO until the FU side accepts them.
- It is the initiator end of the FU operand interface.

---
 rtl/fu_issue.sv | 149 ++++++++++++++
 tb/tb_fu_issue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue.sv
// Issue stage for the ALU/shifter functional unit: decodes RV32I integer ops into
// FU operands and buffers the results in a 2-entry FIFO with a valid/ready handshake.
module fu_issue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] fu_in1,
  output logic [XLEN-1:0] fu_in2,
  output logic [4:0]      funct_select,
  output logic            unit_sel,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      fs;
    logic            us;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  entry_t      w_dec;
  entry_t      w_head;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f7ok;
  logic        w_shift;
  logic [1:0]  w_shift_sel;
  logic        w_push;
  logic        w_pop;

  assign w_funct3    = in_instr[14:12];
  assign w_funct7    = in_instr[31:25];
  assign w_f7ok      = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
  assign w_shift     = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_shift_sel = (w_funct3 == 3'b001) ? 2'b00 : (in_instr[30] ? 2'b11 : 2'b01);

  // Illegal entries keep only rd; every other field stays at the zero default.
  always_comb begin
    w_dec    = '0;
    w_dec.rd = in_instr[11:7];
    case (in_instr[6:0])
      OPC_OP: begin
        if (w_f7ok && !(in_instr[30] && w_funct3 != 3'b000 && w_funct3 != 3'b101)) begin
          w_dec.a = in_rs1;
          w_dec.b = in_rs2;
          if (w_shift) begin
            w_dec.us = 1'b1;
            w_dec.fs = {3'b000, w_shift_sel};
          end else begin
            w_dec.fs = {1'b0, (w_funct3 == 3'b000) & in_instr[30], w_funct3};
          end
        end else begin
          w_dec.ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (w_shift) begin
          if (w_f7ok) begin
            w_dec.a  = in_rs1;
            w_dec.b  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            w_dec.us = 1'b1;
            w_dec.fs = {3'b000, w_shift_sel};
          end else begin
            w_dec.ill = 1'b1;
          end
        end else begin
          w_dec.a  = in_rs1;
          w_dec.b  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          w_dec.fs = {2'b00, w_funct3};
        end
      end
      OPC_LUI: begin
        w_dec.b = {in_instr[31:12], {(XLEN-20){1'b0}}};
      end
      OPC_AUIPC: begin
        w_dec.a = in_pc;
        w_dec.b = {in_instr[31:12], {(XLEN-20){1'b0}}};
      end
      default: w_dec.ill = 1'b1;
    endcase
  end

  // in_ready depends only on the registered count, so a full FIFO never accepts
  // even when the head is popped in the same cycle.
  assign in_ready  = (r_count < 2'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_dec;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_comb begin
    w_head       = r_mem[r_rptr];
    fu_in1       = w_head.a;
    fu_in2       = w_head.b;
    funct_select = w_head.fs;
    unit_sel     = w_head.us;
    rd           = w_head.rd;
    illegal      = w_head.ill;
  end

endmodule

// File: tb/tb_fu_issue.sv
// Bench for fu_issue: decode vector table, handshake corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_fu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] fu_in1;
  logic [31:0] fu_in2;
  logic [4:0]  funct_select;
  logic        unit_sel;
  logic [4:0]  rd;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fu_issue #(.DEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fu_in1       (fu_in1),
    .fu_in2       (fu_in2),
    .funct_select (funct_select),
    .unit_sel     (unit_sel),
    .rd           (rd),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  fs;
    logic        us;
    logic [4:0]  rd;
    logic        ill;
  } op_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  fs;
    logic        us;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  op_t  q[$];
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic op_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2);
    op_t         o;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          f7ok;
    bit          is_shift;
    logic [4:0]  shcode;
    logic [31:0] upper;
    logic [31:0] imm;
    opc      = ins[6:0];
    f3       = ins[14:12];
    f7       = ins[31:25];
    f7ok     = (f7 == 7'h00) || (f7 == 7'h20);
    is_shift = (f3 == 3'd1) || (f3 == 3'd5);
    shcode   = (f3 == 3'd1) ? 5'd0 : (ins[30] ? 5'd3 : 5'd1);
    upper    = ins & 32'hFFFF_F000;
    imm      = 32'($signed(ins) >>> 20);
    o        = '{default: '0};
    o.rd     = ins[11:7];
    if (opc == 7'h33) begin
      if (!f7ok || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5)) o.ill = 1'b1;
      else begin
        o.a  = r1;
        o.b  = r2;
        o.us = is_shift;
        o.fs = is_shift ? shcode : 5'(f3) + ((f3 == 3'd0 && f7 == 7'h20) ? 5'd8 : 5'd0);
      end
    end else if (opc == 7'h13) begin
      if (is_shift && !f7ok) o.ill = 1'b1;
      else begin
        o.a  = r1;
        o.b  = is_shift ? 32'(ins[24:20]) : imm;
        o.us = is_shift;
        o.fs = is_shift ? shcode : 5'(f3);
      end
    end else if (opc == 7'h37) begin
      o.b = upper;
    end else if (opc == 7'h17) begin
      o.a = pc;
      o.b = upper;
    end else begin
      o.ill = 1'b1;
    end
    return o;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk({tag, ".fu_in1"}, fu_in1, q[0].a);
      chk({tag, ".fu_in2"}, fu_in2, q[0].b);
      chk({tag, ".funct_select"}, 32'(funct_select), 32'(q[0].fs));
      chk({tag, ".unit_sel"}, 32'(unit_sel), 32'(q[0].us));
      chk({tag, ".rd"}, 32'(rd), 32'(q[0].rd));
      chk({tag, ".illegal"}, 32'(illegal), 32'(q[0].ill));
    end
  endtask

  // Drive one cycle starting at posedge+1; model updates after the edge.
  task automatic cycle(input string tag, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                       input bit ordy, input bit fl);
    bit push;
    bit pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_rs1    = r1;
    in_rs2    = r2;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_state(tag);
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_dec(ins, pc, r1, r2));
    end
  endtask

  function automatic logic [31:0] addi(input int unsigned k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    tbl[0]  = '{32'h002081B3, 32'h0,    32'h5,        32'h7,  32'h5,        32'h7,        5'h00, 1'b0, 5'd3,  1'b0};
    tbl[1]  = '{32'h4030D113, 32'h0,    32'h80000000, 32'h55, 32'h80000000, 32'h3,        5'h03, 1'b1, 5'd2,  1'b0};
    tbl[2]  = '{32'h402081B3, 32'h0,    32'd10,       32'd4,  32'd10,       32'd4,        5'h08, 1'b0, 5'd3,  1'b0};
    tbl[3]  = '{32'hFFF00093, 32'h0,    32'h11,       32'h99, 32'h11,       32'hFFFFFFFF, 5'h00, 1'b0, 5'd1,  1'b0};
    tbl[4]  = '{32'h123452B7, 32'h40,   32'h77,       32'h88, 32'h0,        32'h12345000, 5'h00, 1'b0, 5'd5,  1'b0};
    tbl[5]  = '{32'hABCDE317, 32'h1000, 32'h77,       32'h88, 32'h1000,     32'hABCDE000, 5'h00, 1'b0, 5'd6,  1'b0};
    tbl[6]  = '{32'h0020D233, 32'h0,    32'hF0,       32'h4,  32'hF0,       32'h4,        5'h01, 1'b1, 5'd4,  1'b0};
    tbl[7]  = '{32'h01F09393, 32'h0,    32'h1,        32'h9,  32'h1,        32'd31,       5'h00, 1'b1, 5'd7,  1'b0};
    tbl[8]  = '{32'h022081B3, 32'h0,    32'h5,        32'h7,  32'h0,        32'h0,        5'h00, 1'b0, 5'd3,  1'b1};
    tbl[9]  = '{32'h402091B3, 32'h0,    32'h5,        32'h7,  32'h0,        32'h0,        5'h00, 1'b0, 5'd3,  1'b1};
    tbl[10] = '{32'h02109393, 32'h0,    32'h5,        32'h7,  32'h0,        32'h0,        5'h00, 1'b0, 5'd7,  1'b1};
    tbl[11] = '{32'h00000FFF, 32'h20,   32'h5,        32'h7,  32'h0,        32'h0,        5'h00, 1'b0, 5'd31, 1'b1};
    tbl[12] = '{32'h8004F413, 32'h0,    32'h1234,     32'h7,  32'h1234,     32'hFFFFF800, 5'h07, 1'b0, 5'd8,  1'b0};
    tbl[13] = '{32'h4020D233, 32'h0,    32'h8,        32'h1,  32'h8,        32'h1,        5'h03, 1'b1, 5'd4,  1'b0};
    tbl[14] = '{32'h0050D213, 32'h0,    32'h40,       32'h7,  32'h40,       32'd5,        5'h01, 1'b1, 5'd4,  1'b0};
    tbl[15] = '{32'h40000093, 32'h0,    32'h3,        32'h7,  32'h3,        32'h400,      5'h00, 1'b0, 5'd1,  1'b0};
    tbl[16] = '{32'h0020A1B3, 32'h0,    32'h1,        32'h2,  32'h1,        32'h2,        5'h02, 1'b0, 5'd3,  1'b0};

    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.fu_in1", fu_in1, 32'd0);
    chk("rst.fu_in2", fu_in2, 32'd0);
    chk("rst.fs_us_rd_ill", {18'd0, funct_select, unit_sel, rd, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode table: push with FU ready, check next cycle, let it pop
    for (int i = 0; i < 17; i++) begin
      cycle("tbl.push", 1'b1, tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, 1'b1, 1'b0);
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d.fu_in1", i), fu_in1, tbl[i].a);
      chk($sformatf("tbl%0d.fu_in2", i), fu_in2, tbl[i].b);
      chk($sformatf("tbl%0d.funct_select", i), 32'(funct_select), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d.unit_sel", i), 32'(unit_sel), 32'(tbl[i].us));
      chk($sformatf("tbl%0d.rd", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d.illegal", i), 32'(illegal), 32'(tbl[i].ill));
      cycle("tbl.pop", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    end

    // Backpressure: third instruction held until count drops below 2
    cycle("bp", 1'b1, addi(1), '0, '0, '0, 1'b0, 1'b0);
    chk("bp.ready_after1", 32'(in_ready), 32'd1);
    cycle("bp", 1'b1, addi(2), '0, '0, '0, 1'b0, 1'b0);
    chk("bp.ready_after2", 32'(in_ready), 32'd0);
    cycle("bp", 1'b1, addi(3), '0, '0, '0, 1'b0, 1'b0);
    chk("bp.held_head", fu_in2, 32'd1);
    chk("bp.held_ready", 32'(in_ready), 32'd0);
    cycle("bp", 1'b1, addi(3), '0, '0, '0, 1'b1, 1'b0);
    chk("bp.pop1_head", fu_in2, 32'd2);
    chk("bp.pop1_ready", 32'(in_ready), 32'd1);
    cycle("bp", 1'b1, addi(3), '0, '0, '0, 1'b1, 1'b0);
    chk("bp.pop2_head", fu_in2, 32'd3);
    chk("bp.pop2_valid", 32'(out_valid), 32'd1);
    cycle("bp", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Streaming at count = 1
    cycle("st", 1'b1, addi(10), '0, '0, '0, 1'b0, 1'b0);
    for (int unsigned k = 11; k < 19; k++) begin
      cycle("st", 1'b1, addi(k), '0, '0, '0, 1'b1, 1'b0);
      chk($sformatf("st%0d.head", k), fu_in2, 32'(k));
      chk($sformatf("st%0d.ready", k), 32'(in_ready), 32'd1);
    end
    cycle("st", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

    // Flush with full FIFO and a same-cycle push
    cycle("fl", 1'b1, addi(20), '0, '0, '0, 1'b0, 1'b0);
    cycle("fl", 1'b1, addi(21), '0, '0, '0, 1'b0, 1'b0);
    cycle("fl", 1'b1, addi(22), '0, '0, '0, 1'b1, 1'b1);
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    cycle("fl", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    chk("fl.lost", 32'(out_valid), 32'd0);

    // Asynchronous reset with a full FIFO, then an illegal opcode
    cycle("ar", 1'b1, 32'h4030D113, '0, 32'h1234, '0, 1'b0, 1'b0);
    cycle("ar", 1'b1, addi(5), '0, '0, '0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.fu_in1", fu_in1, 32'd0);
    chk("ar.fs_us_rd", {21'd0, funct_select, unit_sel, rd}, 32'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("ill", 1'b1, 32'h0000007F, 32'h44, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0);
    chk("ill.illegal", 32'(illegal), 32'd1);
    chk("ill.fu_in1", fu_in1, 32'd0);
    chk("ill.fu_in2", fu_in2, 32'd0);
    cycle("ill", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0]  opc;
      int unsigned sel;
      int unsigned f7sel;
      ins   = $urandom;
      sel   = $urandom_range(0, 5);
      f7sel = $urandom_range(0, 3);
      case (sel)
        0:       opc = 7'h33;
        1, 5:    opc = 7'h13;
        2:       opc = 7'h37;
        3:       opc = 7'h17;
        default: opc = 7'($urandom);
      endcase
      ins[6:0] = opc;
      if (f7sel == 0) ins[31:25] = 7'h00;
      else if (f7sel == 1) ins[31:25] = 7'h20;
      cycle("rnd", ($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    cycle("end", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    cycle("end", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
